// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the program-counter datapath.
//   - pc_src_e   : next-PC source encodings driven by the controller
//   - DEF_*      : default geometry for the 32-bit core
//   - CLA_GROUP  : lookahead group size used by cla_adder_n
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'b00,   // pc + INC
        PC_SRC_BR  = 2'b01,   // conditional PC-relative branch
        PC_SRC_J   = 2'b10,   // pseudo-direct jump (index field)
        PC_SRC_JR  = 2'b11    // jump to register value
    } pc_src_e;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_JIDX_W     = 26;
    localparam int DEF_INC        = 4;
    localparam int DEF_ALIGN_BITS = 2;
    localparam int CLA_GROUP      = 4;

endpackage

// File: rtl/cla_adder_n.sv
// N-bit carry-lookahead adder built from chained 4-bit lookahead groups.
// Each group computes its internal carries in two-level form from its
// generate/propagate terms; group carries ripple from one group to the next.
// Ports:
//   X, Y : addends (WIDTH bits)
//   Cin  : carry in
//   S    : sum modulo 2^WIDTH
//   Cout : carry out of the top group
// WIDTH must be a multiple of 4.
module cla_adder_n
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NGROUPS = WIDTH / CLA_GROUP;

    // carry into each group; carry[NGROUPS] is the final carry out
    logic [NGROUPS:0] carry;

    assign carry[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < NGROUPS; gi++) begin : g_grp
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] c;

            assign g = X[gi*4 +: 4] & Y[gi*4 +: 4];
            assign p = X[gi*4 +: 4] ^ Y[gi*4 +: 4];

            assign c[0] = carry[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign S[gi*4 +: 4] = p ^ c[3:0];
            assign carry[gi+1]  = c[4];
        end
    endgenerate

    assign Cout = carry[NGROUPS];

endmodule

// File: rtl/pc_unit_param.sv
// Parametrised program-counter unit for the multi-cycle CPU.
// Holds the PC, selects the next PC (sequential / branch / jump / register),
// captures a link address and traps misaligned targets with a sticky flag.
// Ports:
//   CLK, Reset   : clock and synchronous active-high reset
//   pc_wre       : PC write enable (one update per assertion)
//   pc_src       : next-PC source, see cpu_pkg::pc_src_e
//   br_take      : branch condition, only meaningful for branches
//   imm          : sign-extended word offset for branches
//   jidx         : jump index field
//   reg_tgt      : register-jump target
//   link_en      : capture pc+INC of the pre-update PC into ret_addr
//   err_clr      : clear misalign_err (suppresses the update that cycle)
//   pc           : current PC
//   pc_next_seq  : pc+INC (combinational)
//   ret_addr     : link address
//   misalign_err : sticky misaligned-target flag
//   bad_target   : last offending target
module pc_unit_param
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               JIDX_W     = DEF_JIDX_W,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               INC        = DEF_INC,
    parameter int               ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              pc_wre,
    input  logic [1:0]        pc_src,
    input  logic              br_take,
    input  logic [WIDTH-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [WIDTH-1:0]  reg_tgt,
    input  logic              link_en,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_next_seq,
    output logic [WIDTH-1:0]  ret_addr,
    output logic              misalign_err,
    output logic [WIDTH-1:0]  bad_target
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] ret_addr_reg;
    logic             misalign_err_reg;
    logic [WIDTH-1:0] bad_target_reg;

    logic [WIDTH-1:0] seq_sum;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_sum;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] target_next;
    logic             misaligned;
    logic             inc_cout_unused;
    logic             br_cout_unused;

    // Incrementer: pc + INC, carry discarded so the PC wraps naturally.
    cla_adder_n #(.WIDTH(WIDTH)) u_inc (
        .X    (pc_reg),
        .Y    (INC_W),
        .Cin  (1'b0),
        .S    (seq_sum),
        .Cout (inc_cout_unused)
    );

    assign pc_next_seq = seq_sum;

    // imm is a word offset; scale to bytes before adding.
    assign br_offset = imm << 2;

    cla_adder_n #(.WIDTH(WIDTH)) u_br (
        .X    (seq_sum),
        .Y    (br_offset),
        .Cin  (1'b0),
        .S    (br_sum),
        .Cout (br_cout_unused)
    );

    // Pseudo-direct jump keeps the upper region bits of pc+INC, if any exist.
    generate
        if (WIDTH > JIDX_W + 2) begin : g_jump_upper
            assign jump_target = {seq_sum[WIDTH-1:JIDX_W+2], jidx, 2'b00};
        end else begin : g_jump_full
            assign jump_target = {jidx, 2'b00};
        end
    endgenerate

    always_comb begin
        target_next = seq_sum;
        case (pc_src_e'(pc_src))
            PC_SRC_SEQ: target_next = seq_sum;
            PC_SRC_BR:  target_next = br_take ? br_sum : seq_sum;
            PC_SRC_J:   target_next = jump_target;
            PC_SRC_JR:  target_next = reg_tgt;
            default:    target_next = seq_sum;
        endcase
    end

    // Only the selected target is checked, so an untaken branch never traps.
    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign misaligned = |target_next[ALIGN_BITS-1:0];
        end else begin : g_align_none
            assign misaligned = 1'b0;
        end
    endgenerate

    // err_clr takes precedence over pc_wre; while the flag is set the PC is
    // frozen so the faulting state stays inspectable.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_reg           <= RESET_PC;
            ret_addr_reg     <= '0;
            misalign_err_reg <= 1'b0;
            bad_target_reg   <= '0;
        end else if (err_clr) begin
            misalign_err_reg <= 1'b0;
        end else if (pc_wre && !misalign_err_reg) begin
            if (misaligned) begin
                misalign_err_reg <= 1'b1;
                bad_target_reg   <= target_next;
            end else begin
                pc_reg <= target_next;
                if (link_en) begin
                    ret_addr_reg <= seq_sum;
                end
            end
        end
    end

    assign pc           = pc_reg;
    assign ret_addr     = ret_addr_reg;
    assign misalign_err = misalign_err_reg;
    assign bad_target   = bad_target_reg;

endmodule

// File: tb/tb_pc_unit_param.sv
module tb_pc_unit_param;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        err;
        logic [31:0] bad;
    } exp_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ret;
    } exp16_t;

    int checks = 0;
    int errors = 0;

    exp_t   sb[$];
    exp16_t sb16[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit default instance
    logic        reset_a   = 1'b0;
    logic        wre_a     = 1'b0;
    logic [1:0]  src_a     = 2'b00;
    logic        bt_a      = 1'b0;
    logic [31:0] imm_a     = '0;
    logic [25:0] jidx_a    = '0;
    logic [31:0] rt_a      = '0;
    logic        le_a      = 1'b0;
    logic        ec_a      = 1'b0;
    logic [31:0] pc_a, nseq_a, ret_a, bad_a;
    logic        err_a;

    pc_unit_param u_dut (
        .CLK          (clk),
        .Reset        (reset_a),
        .pc_wre       (wre_a),
        .pc_src       (src_a),
        .br_take      (bt_a),
        .imm          (imm_a),
        .jidx         (jidx_a),
        .reg_tgt      (rt_a),
        .link_en      (le_a),
        .err_clr      (ec_a),
        .pc           (pc_a),
        .pc_next_seq  (nseq_a),
        .ret_addr     (ret_a),
        .misalign_err (err_a),
        .bad_target   (bad_a)
    );

    // 16-bit instance for the parameter sweep
    logic        reset_b   = 1'b0;
    logic        wre_b     = 1'b0;
    logic [1:0]  src_b     = 2'b00;
    logic        bt_b      = 1'b0;
    logic [15:0] imm_b     = '0;
    logic [11:0] jidx_b    = '0;
    logic [15:0] rt_b      = '0;
    logic        le_b      = 1'b0;
    logic        ec_b      = 1'b0;
    logic [15:0] pc_b, nseq_b, ret_b, bad_b;
    logic        err_b;

    pc_unit_param #(
        .WIDTH      (16),
        .JIDX_W     (12),
        .RESET_PC   (16'h0100),
        .INC        (4),
        .ALIGN_BITS (2)
    ) u_dut16 (
        .CLK          (clk),
        .Reset        (reset_b),
        .pc_wre       (wre_b),
        .pc_src       (src_b),
        .br_take      (bt_b),
        .imm          (imm_b),
        .jidx         (jidx_b),
        .reg_tgt      (rt_b),
        .link_en      (le_b),
        .err_clr      (ec_b),
        .pc           (pc_b),
        .pc_next_seq  (nseq_b),
        .ret_addr     (ret_b),
        .misalign_err (err_b),
        .bad_target   (bad_b)
    );

    // Apply one cycle of stimulus to the 32-bit DUT; returns 1ns after the edge.
    task automatic drive_a(input logic rst, input logic wre, input logic [1:0] src,
                           input logic bt, input logic [31:0] im, input logic [25:0] ji,
                           input logic [31:0] rt, input logic le, input logic ec);
        reset_a = rst; wre_a = wre; src_a = src; bt_a = bt; imm_a = im;
        jidx_a = ji; rt_a = rt; le_a = le; ec_a = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic rst, input logic wre, input logic [1:0] src,
                           input logic [11:0] ji, input logic le);
        reset_b = rst; wre_b = wre; src_b = src; jidx_b = ji; le_b = le;
        @(posedge clk);
        #1;
    endtask

    // One scoreboard transaction on the 32-bit DUT: push expectation, drive,
    // pop and compare.
    task automatic txn_a(input string name, input exp_t e_in,
                         input logic rst, input logic wre, input logic [1:0] src,
                         input logic bt, input logic [31:0] im, input logic [25:0] ji,
                         input logic [31:0] rt, input logic le, input logic ec);
        exp_t e;
        exp_t got;
        sb.push_back(e_in);
        drive_a(rst, wre, src, bt, im, ji, rt, le, ec);
        got = '{pc: pc_a, ret: ret_a, err: err_a, bad: bad_a};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h ret=%h err=%b bad=%h, expected pc=%h ret=%h err=%b bad=%h",
                     name, got.pc, got.ret, got.err, got.bad, e.pc, e.ret, e.err, e.bad);
        end else begin
            $display("txn %s: pc=%h ret=%h err=%b bad=%h", name, got.pc, got.ret, got.err, got.bad);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            txn_a($sformatf("reset_%0d", i), '{pc: 32'h0, ret: 32'h0, err: 1'b0, bad: 32'h0},
                  1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h500, 1'b1, 1'b0);
        // combinational pc+INC straight out of reset
        checks++;
        if (nseq_a !== 32'h4) begin
            errors++;
            $display("FAIL reset_nseq: got %h expected %h", nseq_a, 32'h4);
        end else begin
            $display("txn reset_nseq: pc_next_seq=%h", nseq_a);
        end
    endtask

    task automatic test_seq();
        for (int i = 1; i <= 3; i++)
            txn_a($sformatf("seq_%0d", i), '{pc: 32'(4 * i), ret: 32'h0, err: 1'b0, bad: 32'h0},
                  1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        txn_a("br_setup1", '{pc: 32'h100, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h100, 1'b0, 1'b0);
        txn_a("br_taken", '{pc: 32'h0FC, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        txn_a("br_setup2", '{pc: 32'h100, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h100, 1'b0, 1'b0);
        txn_a("br_untaken", '{pc: 32'h104, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
        txn_a("br_no_wre", '{pc: 32'h104, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0010, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_jump_link();
        txn_a("j_setup", '{pc: 32'h4000_0010, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h4000_0010, 1'b0, 1'b0);
        txn_a("j_link", '{pc: 32'h4000_048C, ret: 32'h4000_0014, err: 1'b0, bad: 32'h0},
              1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 26'h0000123, 32'h0, 1'b1, 1'b0);
        txn_a("link_no_wre", '{pc: 32'h4000_048C, ret: 32'h4000_0014, err: 1'b0, bad: 32'h0},
              1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_misalign();
        txn_a("mis_raise", '{pc: 32'h4000_048C, ret: 32'h4000_0014, err: 1'b1, bad: 32'h202},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h202, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            txn_a($sformatf("mis_frozen_%0d", i),
                  '{pc: 32'h4000_048C, ret: 32'h4000_0014, err: 1'b1, bad: 32'h202},
                  1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h301, 1'b1, 1'b0);
        txn_a("mis_clear", '{pc: 32'h4000_048C, ret: 32'h4000_0014, err: 1'b0, bad: 32'h202},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
        txn_a("mis_resume", '{pc: 32'h200, ret: 32'h4000_0014, err: 1'b0, bad: 32'h202},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        txn_a("wrap_setup", '{pc: 32'hFFFF_FFFC, ret: 32'h4000_0014, err: 1'b0, bad: 32'h202},
              1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        txn_a("wrap_seq", '{pc: 32'h0, ret: 32'h4000_0014, err: 1'b0, bad: 32'h202},
              1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        txn_a("reset_mid_setup", '{pc: 32'h4, ret: 32'h4, err: 1'b0, bad: 32'h202},
              1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
        txn_a("reset_mid", '{pc: 32'h0, ret: 32'h0, err: 1'b0, bad: 32'h0},
              1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h300, 1'b1, 1'b0);
    endtask

    task automatic test_param16();
        exp16_t e;
        exp16_t got;
        sb16.push_back('{pc: 16'h0100, ret: 16'h0000});
        drive_b(1'b1, 1'b1, 2'b10, 12'hABC, 1'b1);
        got = '{pc: pc_b, ret: ret_b};
        e = sb16.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL p16_reset: got pc=%h ret=%h, expected pc=%h ret=%h", got.pc, got.ret, e.pc, e.ret);
        end else begin
            $display("txn p16_reset: pc=%h ret=%h", got.pc, got.ret);
        end

        sb16.push_back('{pc: 16'h2AF0, ret: 16'h0104});
        drive_b(1'b0, 1'b1, 2'b10, 12'hABC, 1'b1);
        got = '{pc: pc_b, ret: ret_b};
        e = sb16.pop_front();
        checks++;
        if (got !== e || err_b !== 1'b0) begin
            errors++;
            $display("FAIL p16_jump: got pc=%h ret=%h err=%b, expected pc=%h ret=%h err=0",
                     got.pc, got.ret, err_b, e.pc, e.ret);
        end else begin
            $display("txn p16_jump: pc=%h ret=%h", got.pc, got.ret);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump_link();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_param16();
        if (sb.size() != 0 || sb16.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", sb.size(), sb16.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
